// File: rtl/fp16_div_seq.sv
// Multi-cycle binary16 divider: restoring radix-2 mantissa divide with special-case bypass.
// Optional macro FP16_DIV_RNE_EN adds a guard iteration and round-to-nearest-even.
module fp16_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        exc,
    output logic        busy
);

`ifdef FP16_DIV_RNE_EN
    localparam int N = 13;
`else
    localparam int N = 12;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          sa, sb;
    logic [4:0]    ea, eb;
    logic [9:0]    mb;
    logic [11:0]   rem;
    logic [N-1:0]  qr;
    logic [3:0]    cnt;

    // Operand field decode with subnormals flushed to signed zero
    logic [4:0] a_e, b_e;
    logic [9:0] a_m, b_m;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    logic [15:0] sp_q;

    assign a_e    = a[14:10];
    assign b_e    = b[14:10];
    assign a_m    = (a_e == 5'd0) ? 10'd0 : a[9:0];
    assign b_m    = (b_e == 5'd0) ? 10'd0 : b[9:0];
    assign a_zero = (a_e == 5'd0);
    assign b_zero = (b_e == 5'd0);
    assign a_inf  = (a_e == 5'h1F) && (a_m == 10'd0);
    assign b_inf  = (b_e == 5'h1F) && (b_m == 10'd0);
    assign a_nan  = (a_e == 5'h1F) && (a_m != 10'd0);
    assign b_nan  = (b_e == 5'h1F) && (b_m != 10'd0);
    assign special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;

    // Special-case result, first match in priority order wins
    always_comb begin
        sp_q = 16'h0000;
        if (a_nan)                 sp_q = {a[15], 5'h1F, a_m};
        else if (b_nan)            sp_q = {b[15], 5'h1F, b_m};
        else if (a_inf && b_inf)   sp_q = 16'h7E00;
        else if (a_zero && b_zero) sp_q = 16'h7E00;
        else if (a_inf)            sp_q = {a[15] ^ b[15], 15'h7C00};
        else if (b_inf)            sp_q = {a[15] ^ b[15], 15'h0000};
        else if (b_zero)           sp_q = {a[15] ^ b[15], 15'h7C00};
        else                       sp_q = {a[15] ^ b[15], 15'h0000};
    end

    // One restoring step: subtract divisor when it fits, then shift
    logic [11:0] dvs;
    logic        ge;
    logic [11:0] rem_sub;

    assign dvs     = {2'b01, mb};
    assign ge      = (rem >= dvs);
    assign rem_sub = ge ? (rem - dvs) : rem;

    // Exponent and mantissa selection from the quotient's leading one
    logic signed [6:0] e_raw;
    logic signed [6:0] e_fin;
    logic [9:0]        mant_t;
    logic [9:0]        mant_f;
    logic [15:0]       nq;

    always_comb begin
        e_raw = $signed({2'b00, ea}) - $signed({2'b00, eb})
              + (qr[N-1] ? 7'sd15 : 7'sd14);
        mant_t = qr[N-1] ? qr[N-2 -: 10] : qr[N-3 -: 10];
    end

`ifdef FP16_DIV_RNE_EN
    logic        guard, sticky, rnd;
    logic [10:0] mant_inc;

    // Round to nearest even; a mantissa carry bumps the exponent
    always_comb begin
        guard    = qr[N-1] ? qr[1] : qr[0];
        sticky   = (rem != 12'd0) || (qr[N-1] && qr[0]);
        rnd      = guard && (sticky || mant_t[0]);
        mant_inc = {1'b0, mant_t} + {10'd0, rnd};
        mant_f   = mant_inc[9:0];
        e_fin    = mant_inc[10] ? (e_raw + 7'sd1) : e_raw;
    end
`else
    assign mant_f = mant_t;
    assign e_fin  = e_raw;
`endif

    // Saturate to Inf on overflow and to zero on underflow
    always_comb begin
        if (e_fin >= 7'sd31)     nq = {sa ^ sb, 15'h7C00};
        else if (e_fin <= 7'sd0) nq = {sa ^ sb, 15'h0000};
        else                     nq = {sa ^ sb, e_fin[4:0], mant_f};
    end

    // Control FSM with registered result and operand state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= 16'h0000;
            exc   <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            ea    <= 5'd0;
            eb    <= 5'd0;
            mb    <= 10'd0;
            rem   <= 12'd0;
            qr    <= '0;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa <= a[15];
                        sb <= b[15];
                        ea <= a_e;
                        eb <= b_e;
                        mb <= b_m;
                        if (special) begin
                            q     <= sp_q;
                            exc   <= 1'b1;
                            state <= DONE;
                        end else begin
                            rem   <= {2'b01, a_m};
                            qr    <= '0;
                            cnt   <= 4'd0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_sub << 1;
                    qr  <= {qr[N-2:0], ge};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(N - 1)) state <= NORM;
                end
                NORM: begin
                    q     <= nq;
                    exc   <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed-vector bench for fp16_div_seq.
// Latency and the rounding-sensitive vector follow FP16_DIV_RNE_EN.
module tb_fp16_div_seq;

`ifdef FP16_DIV_RNE_EN
    localparam int LAT_N = 15;
    localparam logic [15:0] Q_RND = 16'h4001;
`else
    localparam int LAT_N = 14;
    localparam logic [15:0] Q_RND = 16'h4000;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        exc;
    logic        busy;

    int checks;
    int failures;

    fp16_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .exc       (exc),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for out_valid; lat=1 means the cycle after accept
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] eq,
                       input logic eexc, input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".rdy"}, in_ready, 1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".q"}, q, eq);
        check({tag, ".exc"}, exc, eexc);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".ovl"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.q", q, 0);
        check("rst.exc", exc, 0);
        rst = 1'b0;

        run("one_half", 16'h3C00, 16'h4000, 16'h3800, 1'b0, LAT_N);
        run("third",    16'h3C00, 16'h4200, 16'h3555, 1'b0, LAT_N);
        run("rnd",      16'h4201, 16'h3E00, Q_RND,    1'b0, LAT_N);
        run("nan_a",    16'h7E01, 16'h3C00, 16'h7E01, 1'b1, 1);
        run("inf_inf",  16'h7C00, 16'hFC00, 16'h7E00, 1'b1, 1);
        run("div_zero", 16'h3C00, 16'h8000, 16'hFC00, 1'b1, 1);
        run("zero_zero",16'h0000, 16'h0000, 16'h7E00, 1'b1, 1);
        run("ovf",      16'h7BFF, 16'h0400, 16'h7C00, 1'b0, LAT_N);
        run("unf",      16'h0400, 16'h7BFF, 16'h0000, 1'b0, LAT_N);

        // Backpressure: result held, stray input ignored
        @(negedge clk);
        a = 16'h3C00;
        b = 16'h4000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        check("bp.lat", lat, LAT_N);
        a = 16'h7E01;
        b = 16'h3C00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.q", q, 16'h3800);
            check("bp.in_ready", in_ready, 0);
            check("bp.out_valid", out_valid, 1);
        end
        a = 16'h3C00;
        b = 16'h4200;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.rel_rdy", in_ready, 1);
        check("bp.rel_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.accept", busy, 1);
        wait_done(lat);
        check("bp.lat2", lat, LAT_N);
        check("bp.q2", q, 16'h3555);
        check("bp.exc2", exc, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a divide
        @(negedge clk);
        a = 16'h4201;
        b = 16'h3E00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.busy", busy, 0);
        check("mrst.in_ready", in_ready, 1);
        check("mrst.out_valid", out_valid, 0);
        check("mrst.q", q, 0);
        run("post_rst", 16'h3C00, 16'h4000, 16'h3800, 1'b0, LAT_N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
